// File: rtl/noc_credit_rx_port.sv
// Router-side receive port: 7-entry first-word-fall-through FIFO with one credit returned per popped flit.
// Optional sticky overflow flag on ovf_err when NOC_RX_OVF_DETECT_EN is defined.
module noc_credit_rx_port #(
    parameter int DW    = 20,
    parameter int DEPTH = 7,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] datain,
    input  logic          in_valid,
    output logic          co,
    output logic [DW-1:0] dataout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] count
`ifdef NOC_RX_OVF_DETECT_EN
    ,
    output logic          ovf_err
`endif
);

    localparam logic [AW-1:0] LP_FULL = AW'(DEPTH);
    localparam logic [AW-1:0] LP_LAST = AW'(DEPTH - 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_count;
    logic          r_out_valid;
    logic [DW-1:0] r_dataout;
    logic          r_co;

    logic          w_pop;
    logic          w_push_req;
    logic          w_full;
    logic          w_push;
    logic          w_drop;
    logic [AW-1:0] w_rptr_nxt;
    logic [AW-1:0] w_wptr_nxt;
    logic [AW-1:0] w_count_nxt;
    logic [DW-1:0] w_head_nxt;

    // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == LP_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_pop       = r_out_valid & out_ready;
        w_push_req  = in_valid & (|datain);
        w_full      = (r_count == LP_FULL);
        w_push      = w_push_req & (~w_full | w_pop);
        w_drop      = w_push_req & w_full & ~w_pop;
        w_rptr_nxt  = w_pop  ? f_inc(r_rptr) : r_rptr;
        w_wptr_nxt  = w_push ? f_inc(r_wptr) : r_wptr;
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (w_pop && !w_push)
            w_count_nxt = r_count - 1'b1;
        // The new head can be the flit being written this cycle (empty, or last entry popping).
        w_head_nxt = '0;
        if (w_count_nxt != '0) begin
            if (w_push && (r_wptr == w_rptr_nxt))
                w_head_nxt = datain;
            else
                w_head_nxt = r_mem[w_rptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= datain;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_dataout   <= '0;
            r_co        <= 1'b0;
        end else begin
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
            r_dataout   <= w_head_nxt;
            r_co        <= w_pop;
        end
    end

    assign co        = r_co;
    assign dataout   = r_dataout;
    assign out_valid = r_out_valid;
    assign count     = r_count;

`ifdef NOC_RX_OVF_DETECT_EN
    logic r_ovf_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_ovf_err <= 1'b0;
        else if (w_drop)
            r_ovf_err <= 1'b1;
    end

    assign ovf_err = r_ovf_err;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

endmodule

// File: tb/tb_noc_credit_rx_port.sv
// Self-checking bench for noc_credit_rx_port: directed scenarios plus random traffic against a queue model.
module tb_noc_credit_rx_port;

    logic        clk;
    logic        rst;
    logic [19:0] datain;
    logic        in_valid;
    logic        co;
    logic [19:0] dataout;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
`ifdef NOC_RX_OVF_DETECT_EN
    logic        ovf_err;
`endif

    noc_credit_rx_port dut (
        .clk       (clk),
        .rst       (rst),
        .datain    (datain),
        .in_valid  (in_valid),
        .co        (co),
        .dataout   (dataout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
`ifdef NOC_RX_OVF_DETECT_EN
        ,
        .ovf_err   (ovf_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] q[$];
    logic        m_co;
    logic        m_ovf;
    int          pops;
    int          credits;
    int          checks;
    int          failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":count"}, 32'(count), 32'(q.size()));
        chk({tag, ":out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0)
            chk({tag, ":dataout"}, 32'(dataout), 32'(q[0]));
        chk({tag, ":co"}, 32'(co), 32'(m_co));
`ifdef NOC_RX_OVF_DETECT_EN
        chk({tag, ":ovf_err"}, 32'(ovf_err), 32'(m_ovf));
`endif
    endtask

    // One clock of traffic; the model applies the FIFO rules to the queue at the edge.
    task automatic step(input string tag, input logic v, input logic [19:0] d, input logic r);
        bit do_pop, do_push, do_drop;
        in_valid  = v;
        datain    = d;
        out_ready = r;
        do_pop  = (q.size() != 0) && r;
        do_push = v && (d != 0) && ((q.size() < 7) || do_pop);
        do_drop = v && (d != 0) && !do_push;
        @(posedge clk);
        #1;
        if (do_pop) begin
            void'(q.pop_front());
            pops++;
        end
        if (do_push) q.push_back(d);
        if (do_drop) m_ovf = 1'b1;
        m_co = do_pop;
        if (co === 1'b1) credits++;
        check_outputs(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ":count"}, 32'(count), 32'd0);
        chk({tag, ":out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ":dataout"}, 32'(dataout), 32'd0);
        chk({tag, ":co"}, 32'(co), 32'd0);
`ifdef NOC_RX_OVF_DETECT_EN
        chk({tag, ":ovf_err"}, 32'(ovf_err), 32'd0);
`endif
    endtask

    initial begin
        logic [19:0] rd;
        checks = 0; failures = 0; pops = 0; credits = 0;
        m_co = 1'b0; m_ovf = 1'b0;
        rst = 1'b0; in_valid = 1'b0; datain = '0; out_ready = 1'b0;

        // Reset held for three cycles, then idle
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all_zero("reset");
        end
        rst = 1'b1;
        repeat (10) step("idle", 1'b0, 20'h0, 1'b0);

        // Fill with backpressure, then drain
        for (int i = 1; i <= 7; i++) step("fill", 1'b1, 20'(i), 1'b0);
        chk("fill_head", 32'(dataout), 32'h1);
        for (int i = 0; i < 7; i++) step("drain", 1'b0, 20'h0, 1'b1);
        step("drain_tail", 1'b0, 20'h0, 1'b0);
        chk("drain_credits", 32'(credits), 32'd7);

        // Push and pop together while full
        for (int i = 1; i <= 7; i++) step("refill", 1'b1, 20'(i), 1'b0);
        step("full_pushpop", 1'b1, 20'h8, 1'b1);
        chk("full_pushpop_count", 32'(count), 32'd7);
        for (int i = 0; i < 6; i++) step("drain2", 1'b0, 20'h0, 1'b1);
        chk("last_is_8", 32'(dataout), 32'h8);
        step("drain2_last", 1'b0, 20'h0, 1'b1);
        step("drain2_tail", 1'b0, 20'h0, 1'b0);

        // Null flit, then overflow while full
        step("null_empty", 1'b1, 20'h0, 1'b0);
        for (int i = 1; i <= 7; i++) step("fill3", 1'b1, 20'h100 + 20'(i), 1'b0);
        step("null_full", 1'b1, 20'h0, 1'b0);
        step("overflow", 1'b1, 20'hABCDE, 1'b0);
        chk("overflow_count", 32'(count), 32'd7);
        step("ovf_hold", 1'b0, 20'h0, 1'b0);
        for (int i = 0; i < 8; i++) step("drain3", 1'b0, 20'h0, 1'b1);

        // Alternating backpressure on three queued flits
        credits = 0;
        step("bp_push", 1'b1, 20'h00A11, 1'b0);
        step("bp_push", 1'b1, 20'h00B22, 1'b0);
        step("bp_push", 1'b1, 20'h00C33, 1'b0);
        for (int i = 0; i < 8; i++) step("bp_alt", 1'b0, 20'h0, (i % 2) == 0);
        chk("bp_credits", 32'(credits), 32'd3);

        // Random traffic
        credits = 0; pops = 0;
        for (int i = 0; i < 400; i++) begin
            rd = ($urandom_range(0, 4) == 0) ? 20'h0 : 20'($urandom);
            step("rand", 1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)));
        end
        step("rand_flush", 1'b0, 20'h0, 1'b1);
        repeat (8) step("rand_flush", 1'b0, 20'h0, 1'b1);
        chk("rand_credits_eq_pops", 32'(credits), 32'(pops));

        // Reset asserted mid-transfer with two flits queued
        step("pre_rst", 1'b1, 20'h12345, 1'b0);
        step("pre_rst", 1'b1, 20'h23456, 1'b0);
        in_valid = 1'b0; datain = '0;
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        m_co = 1'b0; m_ovf = 1'b0;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        rst = 1'b1;
        credits = 0;
        repeat (4) step("post_rst", 1'b0, 20'h0, 1'b1);
        chk("post_rst_credits", 32'(credits), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
